ising_coupler_cell: RTL and testbench
=====================================

Name: ising_coupler_cell

Overview:
- Clocked digital Ising-machine array cell. It carries two oscillator lines through one crossing point of the coupling grid:
  - s: the spin line entering on one side.
  - d: the line entering on the other side.
- Coupled mode: each output is a delayed copy of its own input. The delay depends on the 3-bit coupling weight and on whether the two inputs currently agree. This speeds up or slows down the oscillators so they phase-lock (positive coupling) or anti-lock (negative coupling).
- Shorted mode: used on the array diagonal. It crosses the lines (s to d, d to s) with a fixed delay and no coupling.

Parameters:
- DLY_FAST, 2, clock latency for "speed up" propagation. Legal: 1 <= DLY_FAST < DLY_MID.
- DLY_MID, 4, clock latency for neutral propagation (no coupling, invalid weight, shorted mode).
- DLY_SLOW, 6, clock latency for "slow down" propagation. Legal: DLY_MID < DLY_SLOW <= 16.

Ports:
- clk, input, 1, single clock; all state changes on rising edge.
- rst, input, 1, synchronous active-high reset.
- shorted, input, 1, 1 = diagonal/shorted mode; 0 = coupled mode. Quasi-static.
- weight, input, 3, coupling weight. One-hot encoding: 100 = positive, 010 = none, 001 = negative.
- sin, input, 1, s-line oscillator input.
- din, input, 1, d-line oscillator input.
- sout, output, 1, s-line output.
- dout, output, 1, d-line output.

Behaviour:
- One clock; reset is synchronous and active-high.
- State: two history shift registers, hs and hd, each DLY_SLOW deep. Every cycle, sin is sampled into hs and din into hd.
- Definition: "latency k" means the output value in cycle t equals the corresponding input value sampled in cycle t-k.
- Reset:
  - While rst=1 at a rising edge, all history bits and both outputs clear to 0.
  - A reset asserted mid-operation discards all in-flight transitions.
  - After reset release, outputs stay 0 until a 1 has propagated through the selected latency.
- Agreement: agree = (sin == din), evaluated combinationally on the current-cycle inputs.
- Latency k is selected every cycle from weight and agree. The same k applies to both sout and dout.
  - weight=100: agree gives DLY_FAST; disagree gives DLY_SLOW.
  - weight=001: agree gives DLY_SLOW; disagree gives DLY_FAST.
  - weight=010: DLY_MID.
  - Any non-one-hot weight (000, 011, 101, 110, 111): DLY_MID.
- Coupled mode (shorted=0):
  - sout = sin delayed by k.
  - dout = din delayed by k.
- Shorted mode (shorted=1):
  - weight and agree are ignored.
  - sout = din delayed by DLY_MID.
  - dout = sin delayed by DLY_MID.
- Tap switching:
  - k may change between cycles. The output then simply reads the newly selected tap; transitions may be duplicated, absorbed or shortened.
  - No glitch filtering is required.
  - Outputs are registered: no combinational path from any input to sout/dout.
- Simultaneous edges on sin and din in the same cycle count as agreement in that cycle.
- Weight or mode changes take effect on the next rising edge. History is not flushed.

Test Plan:
- Reset with sin=din=1, rst held for 5 cycles -> sout=dout=0 throughout. Release rst at cycle 5 with weight=010 -> both outputs rise at cycle 9.
- weight=010, shorted=0, din=0, sin steps 0->1 at cycle 10 -> sout rises at cycle 14; dout stays 0.
- weight=100, sin and din both step 0->1 at cycle 10 -> sout and dout both rise at cycle 12 (agree, FAST). Same stimulus with weight=001 -> both rise at cycle 16.
- weight=100, sin steps 0->1 at cycle 10, din=0 -> sout rises at cycle 16 (disagree, SLOW). With weight=001 -> sout rises at cycle 12. dout stays 0 in both cases.
- shorted=1, weight=100, din steps 0->1 at cycle 10, sin=0 -> sout rises at cycle 14, dout stays 0. Then sin steps 0->1 at cycle 20 -> dout rises at cycle 24.
- Invalid weight=111 behaves as 010 (sin step at 10 -> sout at 14). Reset pulsed at cycle 12 mid-flight -> sout stays 0, pending edge lost.

Source files
------------

// File: rtl/ising_coupler_if.sv
// Oscillator line bundle for one Ising coupling-grid crossing: mode, weight, two lines in, two lines out.
interface ising_coupler_if;
  logic       shorted;
  logic [2:0] weight;
  logic       sin;
  logic       din;
  logic       sout;
  logic       dout;

  modport master (
    output shorted,
    output weight,
    output sin,
    output din,
    input  sout,
    input  dout
  );

  modport slave (
    input  shorted,
    input  weight,
    input  sin,
    input  din,
    output sout,
    output dout
  );
endinterface

// File: rtl/ising_coupler_cell.sv
// Ising-machine crossing cell: delays s/d lines by a weight- and agreement-selected latency (coupled)
// or crosses them with a fixed neutral latency (shorted). Outputs registered; no backpressure.
module ising_coupler_cell #(
  parameter int DLY_FAST = 2,
  parameter int DLY_MID  = 4,
  parameter int DLY_SLOW = 6
) (
  input  logic clk,
  input  logic rst,
  ising_coupler_if.slave cpl
);

  localparam int TW = $clog2(DLY_SLOW);
  // History bit i holds the input sampled i+1 edges ago, so latency k reads bit k-1.
  localparam logic [TW-1:0] TAP_FAST = TW'(DLY_FAST - 1);
  localparam logic [TW-1:0] TAP_MID  = TW'(DLY_MID - 1);
  localparam logic [TW-1:0] TAP_SLOW = TW'(DLY_SLOW - 1);

  logic [DLY_SLOW-1:0] hs_q, hs_d;
  logic [DLY_SLOW-1:0] hd_q, hd_d;
  logic                sout_q, sout_d;
  logic                dout_q, dout_d;
  logic                agree;
  logic [TW-1:0]       tap;

  always_comb begin
    agree = (cpl.sin == cpl.din);
    tap   = TAP_MID;
    case (cpl.weight)
      3'b100:  tap = agree ? TAP_FAST : TAP_SLOW;
      3'b001:  tap = agree ? TAP_SLOW : TAP_FAST;
      default: tap = TAP_MID;
    endcase

    hs_d = {hs_q[DLY_SLOW-2:0], cpl.sin};
    hd_d = {hd_q[DLY_SLOW-2:0], cpl.din};

    if (cpl.shorted) begin
      sout_d = hd_q[TAP_MID];
      dout_d = hs_q[TAP_MID];
    end else begin
      sout_d = hs_q[tap];
      dout_d = hd_q[tap];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q   <= '0;
      hd_q   <= '0;
      sout_q <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      hs_q   <= hs_d;
      hd_q   <= hd_d;
      sout_q <= sout_d;
      dout_q <= dout_d;
    end
  end

  assign cpl.sout = sout_q;
  assign cpl.dout = dout_q;

endmodule

// File: tb/tb_ising_coupler_cell.sv
// Scenario bench for ising_coupler_cell: expected outputs are queued as stimulus is driven and popped each cycle.
module tb_ising_coupler_cell;

  typedef struct packed {
    logic s;
    logic d;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  ising_coupler_if ifc ();

  ising_coupler_cell dut (
    .clk (clk),
    .rst (rst),
    .cpl (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply one cycle of inputs, let the rising edge take them, observe 1 time unit later.
  task automatic drive(input logic r, input logic sh, input logic [2:0] w,
                       input logic s, input logic d);
    rst         = r;
    ifc.shorted = sh;
    ifc.weight  = w;
    ifc.sin     = s;
    ifc.din     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int c = 0; c < 14; c++) begin
      exp_q.push_back('{s: (c >= 9), d: (c >= 9)});
      drive(c < 5, 1'b0, 3'b010, 1'b1, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (ifc.sout !== e.s || ifc.dout !== e.d) begin
        failures++;
        $display("FAIL reset c=%0d sout=%b dout=%b expected sout=%b dout=%b",
                 c, ifc.sout, ifc.dout, e.s, e.d);
      end
    end
  endtask

  task automatic test_neutral();
    exp_t e;
    for (int c = 0; c < 20; c++) begin
      exp_q.push_back('{s: (c >= 14), d: 1'b0});
      drive(c < 5, 1'b0, 3'b010, c >= 10, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (ifc.sout !== e.s || ifc.dout !== e.d) begin
        failures++;
        $display("FAIL neutral c=%0d sout=%b dout=%b expected sout=%b dout=%b",
                 c, ifc.sout, ifc.dout, e.s, e.d);
      end
    end
  endtask

  task automatic test_agree();
    exp_t e;
    logic [2:0] w;
    int rise;
    for (int pass = 0; pass < 2; pass++) begin
      w    = (pass == 0) ? 3'b100 : 3'b001;
      rise = (pass == 0) ? 12 : 16;
      for (int c = 0; c < 20; c++) begin
        exp_q.push_back('{s: (c >= rise), d: (c >= rise)});
        drive(c < 5, 1'b0, w, c >= 10, c >= 10);
        e = exp_q.pop_front();
        checks++;
        if (ifc.sout !== e.s || ifc.dout !== e.d) begin
          failures++;
          $display("FAIL agree w=%b c=%0d sout=%b dout=%b expected sout=%b dout=%b",
                   w, c, ifc.sout, ifc.dout, e.s, e.d);
        end
      end
    end
  endtask

  task automatic test_disagree();
    exp_t e;
    logic [2:0] w;
    int rise;
    for (int pass = 0; pass < 2; pass++) begin
      w    = (pass == 0) ? 3'b100 : 3'b001;
      rise = (pass == 0) ? 16 : 12;
      for (int c = 0; c < 20; c++) begin
        exp_q.push_back('{s: (c >= rise), d: 1'b0});
        drive(c < 5, 1'b0, w, c >= 10, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (ifc.sout !== e.s || ifc.dout !== e.d) begin
          failures++;
          $display("FAIL disagree w=%b c=%0d sout=%b dout=%b expected sout=%b dout=%b",
                   w, c, ifc.sout, ifc.dout, e.s, e.d);
        end
      end
    end
  endtask

  task automatic test_shorted();
    exp_t e;
    for (int c = 0; c < 28; c++) begin
      exp_q.push_back('{s: (c >= 14), d: (c >= 24)});
      drive(c < 5, 1'b1, 3'b100, c >= 20, c >= 10);
      e = exp_q.pop_front();
      checks++;
      if (ifc.sout !== e.s || ifc.dout !== e.d) begin
        failures++;
        $display("FAIL shorted c=%0d sout=%b dout=%b expected sout=%b dout=%b",
                 c, ifc.sout, ifc.dout, e.s, e.d);
      end
    end
  endtask

  task automatic test_invalid_reset();
    exp_t e;
    // Step through invalid weight 111: must behave as neutral latency.
    for (int c = 0; c < 18; c++) begin
      exp_q.push_back('{s: (c >= 14), d: 1'b0});
      drive(c < 5, 1'b0, 3'b111, c >= 10, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (ifc.sout !== e.s || ifc.dout !== e.d) begin
        failures++;
        $display("FAIL invalid_w c=%0d sout=%b dout=%b expected sout=%b dout=%b",
                 c, ifc.sout, ifc.dout, e.s, e.d);
      end
    end
    // A pulse in flight at cycle 12 is wiped by a one-cycle reset.
    for (int c = 0; c < 22; c++) begin
      exp_q.push_back('{s: 1'b0, d: 1'b0});
      drive((c < 5) || (c == 12), 1'b0, 3'b111, (c == 10) || (c == 11), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (ifc.sout !== e.s || ifc.dout !== e.d) begin
        failures++;
        $display("FAIL mid_reset c=%0d sout=%b dout=%b expected sout=%b dout=%b",
                 c, ifc.sout, ifc.dout, e.s, e.d);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t raw;
    logic s;
    logic d;
    logic sh;
    logic [2:0] w;
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 3'b010, 1'b1, 1'b1);
      checks++;
      if (ifc.sout !== 1'b0 || ifc.dout !== 1'b0) begin
        failures++;
        $display("FAIL b2b_reset c=%0d sout=%b dout=%b expected 0 0", c, ifc.sout, ifc.dout);
      end
    end
    // Cleared history stands in for the four inputs before release.
    for (int i = 0; i < 4; i++) exp_q.push_back('{s: 1'b0, d: 1'b0});
    for (int c = 0; c < 80; c++) begin
      s  = 1'($urandom_range(0, 1));
      d  = 1'($urandom_range(0, 1));
      sh = (c >= 40);
      w  = sh ? 3'($urandom_range(0, 7)) : 3'b010;
      exp_q.push_back('{s: s, d: d});
      drive(1'b0, sh, w, s, d);
      raw = exp_q.pop_front();
      e   = sh ? '{s: raw.d, d: raw.s} : raw;
      checks++;
      if (ifc.sout !== e.s || ifc.dout !== e.d) begin
        failures++;
        $display("FAIL b2b sh=%b c=%0d sout=%b dout=%b expected sout=%b dout=%b",
                 sh, c, ifc.sout, ifc.dout, e.s, e.d);
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    ifc.shorted = 1'b0;
    ifc.weight  = 3'b010;
    ifc.sin     = 1'b0;
    ifc.din     = 1'b0;
    test_reset();
    test_neutral();
    test_agree();
    test_disagree();
    test_shorted();
    test_invalid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
